demux_1_n: RTL and testbench
============================

DEMUX_1_N -- requirements
Module: demux_1_n

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning data width in bits.
REQ-002 The block SHALL have parameter N, default 4, meaning output channel count, legal range N >= 2.
REQ-003 The block SHALL derive local parameter SELW = max(1, ceil(log2(N))), meaning selector and pointer width.
REQ-004 The block SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, meaning reset, asynchronous and active-low.
REQ-006 The block SHALL have port in_data, input, WIDTH, meaning the input word.
REQ-007 The block SHALL have port in_valid, input, 1, meaning in_data is offered.
REQ-008 The block SHALL have port in_ready, output, 1, meaning the block accepts in_data this cycle (combinational).
REQ-009 The block SHALL have port sel, input, SELW, meaning the target channel in addressed mode.
REQ-010 The block SHALL have port rr_mode, input, 1, meaning 0 = addressed mode and 1 = round-robin mode.
REQ-011 The block SHALL have port out_data, output, N*WIDTH, meaning channel i occupies bits [i*WIDTH +: WIDTH].
REQ-012 The block SHALL have port out_valid, output, N, meaning channel i holds an undelivered word (bit i).
REQ-013 The block SHALL have port out_ready, input, N, meaning the consumer of channel i takes the word (bit i).
REQ-014 The block SHALL have port rr_ptr, output, SELW, meaning the current round-robin pointer.
REQ-015 The block SHALL have port err, output, 1, meaning a one-cycle pulse on discard of an out-of-range word.

Function
REQ-016 target SHALL be rr_ptr when rr_mode=1 and sel when rr_mode=0.
REQ-017 Each channel SHALL have a one-entry holding register; out_data and out_valid SHALL be driven directly from registers.
REQ-018 in_ready SHALL be 1 when target >= N; otherwise it SHALL equal !out_valid[target] || out_ready[target].
REQ-019 Accept SHALL occur when in_valid && in_ready; on accept with target < N, channel target SHALL load in_data and set out_valid on the same edge (latency 1 cycle).
REQ-020 A channel drain SHALL occur when out_valid[i] && out_ready[i], and SHALL clear out_valid[i] unless a refill of channel i happens on the same edge, in which case out_valid[i] stays 1 with the new data.
REQ-021 Channels SHALL drain independently and concurrently; a non-target channel SHALL never be modified by an accept.
REQ-022 out_data slices SHALL hold their last value after a drain; they SHALL NOT be cleared.
REQ-023 rr_ptr SHALL advance by 1 on each accept while rr_mode=1, wrapping from N-1 to 0; otherwise it SHALL hold.
REQ-024 In round-robin mode a full, non-draining target SHALL stall the input (in_ready=0); the block SHALL NOT skip to another channel.
REQ-025 Toggling rr_mode SHALL NOT alter rr_ptr or channel contents.
REQ-026 An accept with rr_mode=0 and sel >= N (possible only for non-power-of-2 N) SHALL discard the word and assert err for exactly the following cycle.
REQ-027 With in_valid=0, no channel SHALL be loaded and rr_ptr and err SHALL be unaffected (err=0 next cycle).

Reset
REQ-028 When rst_n=0, out_valid SHALL be 0 and out_data SHALL be all 0, asynchronously without waiting for a clk edge.
REQ-029 When rst_n=0, rr_ptr SHALL be 0 and err SHALL be 0, asynchronously.
REQ-030 Reset mid-operation SHALL discard all held words; no accept SHALL occur while rst_n=0.
REQ-031 Release of rst_n SHALL take effect at the first clk edge with rst_n=1.

Verification (WIDTH=16, N=4 unless stated)
REQ-032 Reset, then rr_mode=0, sel=2, in_data=16'hA5A5 with in_valid for 1 cycle, out_ready=0 -> out_valid=4'b0100, out_data[47:32]=16'hA5A5, other slices 0, then in_ready=0 while sel=2.
REQ-033 Channel 2 full, out_ready[2]=1, in_data=16'h1234 with sel=2 on the same cycle -> accepted, out_valid[2] stays 1, out_data[47:32]=16'h1234.
REQ-034 rr_mode=1, words 16'h0001 to 16'h0005 sent back-to-back with out_ready=4'b1111 -> channels 0,1,2,3,0 loaded in order; rr_ptr goes 1,2,3,0,1.
REQ-035 rr_mode=1, rr_ptr=1, channel 1 full, out_ready[1]=0 -> in_ready=0, rr_ptr stays 1, channel 2 not written; raising out_ready[1] resumes transfer.
REQ-036 N=3, rr_mode=0, sel=3, in_valid=1 -> in_ready=1, err=1 for exactly one cycle, out_valid unchanged.
REQ-037 rst_n driven low between clk edges while out_valid=4'b1011 and rr_ptr=2 -> out_valid=0, out_data=0, rr_ptr=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/demux_1_n.sv
// demux_1_n: 1-to-N demultiplexer with a one-entry holding register per channel.
// Targets a channel by selector or by a round-robin pointer.
module demux_1_n #(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  localparam int SELW = (N <= 2) ? 1 : $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SELW-1:0]      sel,
  input  logic                 rr_mode,
  output logic [N*WIDTH-1:0]   out_data,
  output logic [N-1:0]         out_valid,
  input  logic [N-1:0]         out_ready,
  output logic [SELW-1:0]      rr_ptr,
  output logic                 err
);

  localparam logic [SELW:0]   LP_N    = (SELW+1)'(N);
  localparam logic [SELW-1:0] LP_LAST = SELW'(N - 1);

  logic [N*WIDTH-1:0] r_data;
  logic [N-1:0]       r_valid;
  logic [SELW-1:0]    r_ptr;
  logic               r_err;

  logic [SELW-1:0]    w_target;
  logic               w_in_range;
  logic               w_tgt_full;
  logic               w_tgt_drain;
  logic               w_accept;
  logic [N-1:0]       w_load;

  assign w_target   = rr_mode ? r_ptr : sel;
  assign w_in_range = {1'b0, w_target} < LP_N;

  always_comb begin
    w_tgt_full  = 1'b0;
    w_tgt_drain = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (w_target == SELW'(i)) begin
        w_tgt_full  = r_valid[i];
        w_tgt_drain = out_ready[i];
      end
    end
  end

  // Out-of-range targets are always accepted so they can be discarded.
  assign in_ready = !w_in_range || !w_tgt_full || w_tgt_drain;
  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_load = '0;
    for (int i = 0; i < N; i++) begin
      w_load[i] = w_accept && w_in_range && (w_target == SELW'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= '0;
      r_ptr   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_accept && !w_in_range;
      if (w_accept && rr_mode) begin
        r_ptr <= (r_ptr == LP_LAST) ? '0 : r_ptr + 1'b1;
      end
      for (int i = 0; i < N; i++) begin
        if (w_load[i]) begin
          r_data[i*WIDTH +: WIDTH] <= in_data;
          r_valid[i]               <= 1'b1;
        end else if (out_ready[i]) begin
          r_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign rr_ptr    = r_ptr;
  assign err       = r_err;

endmodule

// File: tb/tb_demux_1_n.sv
// tb_demux_1_n: directed and random checks of demux_1_n against a
// channel-level reference model (N=4), plus an N=3 out-of-range instance.
module tb_demux_1_n;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  sel;
  logic        rr_mode;
  logic [63:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [1:0]  rr_ptr;
  logic        err;

  logic [15:0] in_data3;
  logic        in_valid3;
  logic        in_ready3;
  logic [1:0]  sel3;
  logic        rr_mode3;
  logic [47:0] out_data3;
  logic [2:0]  out_valid3;
  logic [2:0]  out_ready3;
  logic [1:0]  rr_ptr3;
  logic        err3;

  int errors = 0;
  int checks = 0;

  // reference model state
  bit          mv[4];
  logic [15:0] md[4];
  int          mptr;
  bit          merr;

  always #5 clk = ~clk;

  demux_1_n #(.WIDTH(16), .N(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .rr_mode(rr_mode),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .rr_ptr(rr_ptr), .err(err)
  );

  demux_1_n #(.WIDTH(16), .N(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .sel(sel3), .rr_mode(rr_mode3),
    .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
    .rr_ptr(rr_ptr3), .err(err3)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int tgt();
    return rr_mode ? mptr : int'(sel);
  endfunction

  function automatic bit exp_ready();
    int t = tgt();
    if (t >= 4) return 1'b1;
    return !mv[t] || out_ready[t];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mv[i] = 1'b0;
      md[i] = '0;
    end
    mptr = 0;
    merr = 1'b0;
  endtask

  task automatic model_edge();
    int t;
    bit acc;
    t    = tgt();
    acc  = in_valid && exp_ready();
    merr = acc && (t >= 4);
    for (int i = 0; i < 4; i++)
      if (mv[i] && out_ready[i]) mv[i] = 1'b0;
    if (acc && t < 4) begin
      mv[t] = 1'b1;
      md[t] = in_data;
    end
    if (acc && rr_mode) mptr = (mptr + 1) % 4;
  endtask

  task automatic check_state(input string tag);
    logic [3:0]  ev;
    logic [63:0] ed;
    for (int i = 0; i < 4; i++) begin
      ev[i]           = mv[i];
      ed[i*16 +: 16]  = md[i];
    end
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(ev));
    chk({tag, ".out_data"}, out_data, ed);
    chk({tag, ".rr_ptr"}, 64'(rr_ptr), 64'(mptr));
    chk({tag, ".err"}, 64'(err), 64'(merr));
  endtask

  // Inputs are set at a falling edge; check in_ready, clock, check state.
  task automatic step(input string tag);
    #1;
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(exp_ready()));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_state(tag);
  endtask

  task automatic send(input string tag, input logic [15:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step(tag);
    in_valid = 1'b0;
  endtask

  int rr_exp[5] = '{1, 2, 3, 0, 1};
  int rr_ch[5]  = '{0, 1, 2, 3, 0};

  initial begin
    rst_n      = 1'b0;
    in_data    = '0;
    in_valid   = 1'b0;
    sel        = '0;
    rr_mode    = 1'b0;
    out_ready  = '0;
    in_data3   = '0;
    in_valid3  = 1'b0;
    sel3       = '0;
    rr_mode3   = 1'b0;
    out_ready3 = '0;
    model_reset();

    #3;
    check_state("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step("idle");

    // addressed load into channel 2
    sel = 2'd2;
    send("addr_load", 16'hA5A5);
    chk("addr_load.valid_const", 64'(out_valid), 64'h4);
    chk("addr_load.data_const", out_data, 64'h0000_A5A5_0000_0000);
    #1;
    chk("addr_load.stall", 64'(in_ready), 64'h0);
    step("addr_hold");

    // refill on the same edge as drain
    out_ready = 4'b0100;
    send("refill", 16'h1234);
    chk("refill.valid2", 64'(out_valid[2]), 64'h1);
    chk("refill.data2", 64'(out_data[47:32]), 64'h1234);

    out_ready = 4'b1111;
    step("drain_all");

    // round-robin sweep
    rr_mode = 1'b1;
    for (int k = 0; k < 5; k++) begin
      send("rr_sweep", 16'(k + 1));
      chk("rr_sweep.ptr", 64'(rr_ptr), 64'(rr_exp[k]));
      chk("rr_sweep.data", 64'(out_data[rr_ch[k]*16 +: 16]), 64'(k + 1));
    end

    // fill channel 1 and come back round to it with it still full
    out_ready = 4'b1101;
    send("rr_fill1", 16'h0601);
    send("rr_fill2", 16'h0602);
    send("rr_fill3", 16'h0603);
    send("rr_fill0", 16'h0600);
    chk("rr_wrap.ptr", 64'(rr_ptr), 64'h1);
    send("rr_stall", 16'hBEEF);
    chk("rr_stall.ptr", 64'(rr_ptr), 64'h1);
    chk("rr_stall.data2", 64'(out_data[47:32]), 64'h0602);
    out_ready[1] = 1'b1;
    send("rr_resume", 16'hBEEF);
    chk("rr_resume.data1", 64'(out_data[31:16]), 64'hBEEF);
    chk("rr_resume.ptr", 64'(rr_ptr), 64'h2);

    // mode toggle keeps pointer and contents
    out_ready = 4'b0000;
    rr_mode = 1'b0;
    step("toggle0");
    rr_mode = 1'b1;
    step("toggle1");

    // N=3 out-of-range discard
    sel3      = 2'd3;
    in_valid3 = 1'b1;
    in_data3  = 16'hDEAD;
    #1;
    chk("n3.in_ready", 64'(in_ready3), 64'h1);
    @(negedge clk);
    in_valid3 = 1'b0;
    chk("n3.err", 64'(err3), 64'h1);
    chk("n3.valid", 64'(out_valid3), 64'h0);
    @(negedge clk);
    chk("n3.err_clear", 64'(err3), 64'h0);
    sel3      = 2'd1;
    in_valid3 = 1'b1;
    @(negedge clk);
    in_valid3 = 1'b0;
    chk("n3.load1", 64'(out_valid3), 64'h2);
    chk("n3.load1_err", 64'(err3), 64'h0);
    chk("n3.load1_data", 64'(out_data3), 64'h0000_DEAD_0000);

    // random traffic
    for (int k = 0; k < 300; k++) begin
      in_valid  = 1'($urandom);
      in_data   = 16'($urandom);
      sel       = 2'($urandom);
      rr_mode   = 1'($urandom);
      out_ready = 4'($urandom);
      step("random");
    end

    // asynchronous reset between edges with out_valid=1011, rr_ptr=2
    in_valid  = 1'b0;
    out_ready = 4'b1111;
    step("pre_ar_drain");
    out_ready = 4'b0000;
    rr_mode   = 1'b1;
    while (mptr != 0) send("pre_ar_align", 16'h0);
    out_ready = 4'b1111;
    step("pre_ar_drain2");
    out_ready = 4'b0000;
    send("pre_ar0", 16'h1111);
    send("pre_ar1", 16'h2222);
    rr_mode = 1'b0;
    sel     = 2'd3;
    send("pre_ar3", 16'h4444);
    chk("pre_ar.valid", 64'(out_valid), 64'hB);
    chk("pre_ar.ptr", 64'(rr_ptr), 64'h2);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst.valid", 64'(out_valid), 64'h0);
    chk("async_rst.data", out_data, 64'h0);
    chk("async_rst.ptr", 64'(rr_ptr), 64'h0);
    chk("async_rst.err", 64'(err), 64'h0);
    in_valid = 1'b1;
    @(negedge clk);
    check_state("in_reset");
    in_valid = 1'b0;
    rst_n = 1'b1;
    step("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
